dp_elastic_pipeline_register: RTL and testbench

Parametrised, handshake-based successor to the fixed-field inter-stage pipeline registers. It replaces global stall/flush wiring with a valid/ready interface and a 2-entry skid buffer. This lets any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) absorb one cycle of backpressure without a combinational ready path. It adds per-boundary occupancy and saturating stall/flush counters for hazard-unit tuning.

---
 rtl/dp_pipeline_pkg.sv | 27 ++
 rtl/dp_elastic_pipeline_register_cnt.sv | 23 ++
 rtl/dp_elastic_pipeline_register.sv | 119 +++++++++++
 tb/tb_dp_elastic_pipeline_register.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dp_pipeline_pkg.sv
// Shared types and defaults for the elastic inter-stage pipeline registers.
package dp_pipeline_pkg;

  // Register fill state; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } dp_state_t;

  // ID/EX boundary payload; its width sets the default DATA_W.
  typedef struct packed {
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic [4:0]  A4;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [15:0] PC;
    logic [15:0] PCNext;
    logic [11:0] ExtImm;
  } id_ex_payload_t;

  localparam int DATA_W_DEF = $bits(id_ex_payload_t);
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/dp_elastic_pipeline_register_cnt.sv
// Saturating performance counter: clear beats increment, never wraps.
module dp_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count qualifying cycles, sticking at all-ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                       r_cnt <= '0;
    else if (i_clear)                  r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))   r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dp_elastic_pipeline_register.sv
// Valid/ready pipeline register with a 2-entry skid buffer, flush, and
// stall/flush performance counters. in_ready comes straight from a flop.
module dp_elastic_pipeline_register
  import dp_pipeline_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter bit ZERO_ON_EMPTY = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [1:0]        o_occupancy,
  input  logic              i_cnt_clear,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  dp_state_t         r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, r_skid;
  logic              r_in_ready, r_out_valid;
  logic              w_accept, w_consume, w_stall, w_flush_hit;

  assign w_accept  = i_in_valid & r_in_ready;
  assign w_consume = r_out_valid & i_out_ready;
  assign w_stall   = r_out_valid & ~i_out_ready;

  // A flush counts only if something live is thrown away: a held entry that
  // is not leaving this edge, the skid entry, or a same-cycle accept.
  assign w_flush_hit = i_flush & ((r_state == ST_SKID) |
                                  ((r_state == ST_FULL) & ~w_consume) |
                                  w_accept);

  // State register plus the registered handshake flags derived from next state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_SKID);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
        ST_FULL: begin
          if (w_accept && !w_consume)      w_state_nxt = ST_SKID;
          else if (!w_accept && w_consume) w_state_nxt = ST_EMPTY;
        end
        ST_SKID:  if (w_consume) w_state_nxt = ST_FULL;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Payload storage: main always holds the oldest entry, skid the younger one.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (i_flush) begin
      if (ZERO_ON_EMPTY) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_main <= i_in_data;
        ST_FULL: begin
          if (w_accept && w_consume) r_main <= i_in_data;
          else if (w_accept)         r_skid <= i_in_data;
        end
        ST_SKID:  if (w_consume) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  // Outputs: occupancy mirrors the state encoding; empty slots read as a NOP bubble.
  always_comb begin
    o_occupancy = r_state;
    o_out_data  = (ZERO_ON_EMPTY && !r_out_valid) ? '0 : r_main;
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;

  dp_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_cnt_clear),
    .i_inc   (w_stall),
    .o_cnt   (o_stall_cnt)
  );

  dp_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_cnt_clear),
    .i_inc   (w_flush_hit),
    .o_cnt   (o_flush_cnt)
  );

endmodule

// File: tb/tb_dp_elastic_pipeline_register.sv
// Bench for dp_elastic_pipeline_register: queue-based reference model checked
// every cycle, a vector table for backpressure, and hand-written corner cases.
module tb_dp_elastic_pipeline_register;
  localparam int DW  = 128;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready, cnt_clear;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occ;
  logic [CW-1:0] stall_cnt, flush_cnt;

  dp_elastic_pipeline_register #(.DATA_W(DW), .CNT_W(CW), .ZERO_ON_EMPTY(1'b1)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_occupancy (occ),
    .i_cnt_clear (cnt_clear),
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO of live payloads plus counter values.
  logic [DW-1:0] m_q[$];
  int            m_stall = 0;
  int            m_flush = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ordy;
    logic [1:0] eocc;
    logic [7:0] edata;
    logic [3:0] estall;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("out_valid", DW'(out_valid), DW'(m_q.size() > 0));
    chk("in_ready",  DW'(in_ready),  DW'(m_q.size() < 2));
    chk("occupancy", DW'(occ),       DW'(m_q.size()));
    chk("out_data",  out_data,       (m_q.size() > 0) ? m_q[0] : '0);
    chk("stall_cnt", DW'(stall_cnt), DW'(m_stall));
    chk("flush_cnt", DW'(flush_cnt), DW'(m_flush));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stall = 0;
    m_flush = 0;
  endtask

  // One clock: model computes from the inputs held across the edge, then checks.
  task automatic tick();
    int sz;
    bit acc, con, disc;
    sz   = m_q.size();
    acc  = in_valid && (sz < 2);
    con  = (sz > 0) && out_ready;
    disc = flush && ((sz - int'(con) + int'(acc)) > 0);
    @(posedge clk);
    if (cnt_clear) m_stall = 0;
    else if ((sz > 0) && !out_ready && (m_stall < SAT)) m_stall++;
    if (cnt_clear) m_flush = 0;
    else if (disc && (m_flush < SAT)) m_flush++;
    if (flush) m_q.delete();
    else begin
      if (con) void'(m_q.pop_front());
      if (acc) m_q.push_back(in_data);
    end
    #1;
    chk_model();
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = DW'(d);
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    // Backpressure vectors: {in_valid, data, out_ready, occ, out_data, stall_cnt}.
    tbl[0] = '{1'b1, 8'h11, 1'b0, 2'd1, 8'h11, 4'd0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 2'd2, 8'h11, 4'd1};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 2'd2, 8'h11, 4'd2};
    tbl[3] = '{1'b1, 8'h33, 1'b0, 2'd2, 8'h11, 4'd3};
    tbl[4] = '{1'b1, 8'h33, 1'b0, 2'd2, 8'h11, 4'd4};
    tbl[5] = '{1'b1, 8'h33, 1'b1, 2'd1, 8'h22, 4'd4};
    tbl[6] = '{1'b1, 8'h33, 1'b1, 2'd1, 8'h33, 4'd4};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 2'd0, 8'h00, 4'd4};

    reset = 1'b1; cnt_clear = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    #12;
    chk_model();
    reset = 1'b0;

    // 1: reset mid-stream drops entries immediately
    drive(1'b1, 8'h0A, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h0B, 1'b0, 1'b0); tick();
    chk("fill_occ", DW'(occ), DW'(2));
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_in_ready",  DW'(in_ready),  DW'(1));
    chk("rst_occ",       DW'(occ),       DW'(0));
    chk("rst_stall",     DW'(stall_cnt), DW'(0));
    chk_model();
    #1 reset = 1'b0;

    // 2: streaming at one payload per cycle
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      tick();
      chk("stream_data",  out_data, DW'(i));
      chk("stream_ready", DW'(in_ready), DW'(1));
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    chk("stream_stall", DW'(stall_cnt), DW'(0));

    // 3: backpressure, skid hold and in-order drain
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ordy, 1'b0);
      tick();
      chk($sformatf("bp_occ[%0d]", i),   DW'(occ),       DW'(tbl[i].eocc));
      chk($sformatf("bp_data[%0d]", i),  out_data,       DW'(tbl[i].edata));
      chk($sformatf("bp_stall[%0d]", i), DW'(stall_cnt), DW'(tbl[i].estall));
    end

    // 4: flush in SKID with a simultaneous in_valid
    drive(1'b1, 8'h66, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h77, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h44, 1'b0, 1'b1); tick();
    chk("fl_skid_occ",  DW'(occ),       DW'(0));
    chk("fl_skid_data", out_data,       '0);
    chk("fl_skid_cnt",  DW'(flush_cnt), DW'(1));
    drive(1'b0, 8'h00, 1'b1, 1'b0); tick(); tick();
    chk("fl_no_44", DW'(out_valid), DW'(0));

    // 5: flush with consume on the same edge is not a discard
    cnt_clear = 1'b1; drive(1'b0, 8'h00, 1'b0, 1'b0); tick(); cnt_clear = 1'b0;
    chk("clr_flush", DW'(flush_cnt), DW'(0));
    drive(1'b1, 8'h55, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1); tick();
    chk("fl_cons_cnt", DW'(flush_cnt), DW'(0));
    drive(1'b1, 8'h5A, 1'b0, 1'b1); tick();
    chk("fl_acc_cnt", DW'(flush_cnt), DW'(1));
    drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
    chk("fl_empty_cnt", DW'(flush_cnt), DW'(1));

    // 6: stall counter saturation and clear priority
    cnt_clear = 1'b1; drive(1'b0, 8'h00, 1'b0, 1'b0); tick(); cnt_clear = 1'b0;
    drive(1'b1, 8'h99, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", DW'(stall_cnt), DW'(SAT));
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    chk("sat_clear", DW'(stall_cnt), DW'(0));
    tick();
    chk("sat_resume", DW'(stall_cnt), DW'(1));
    chk("sat_data",   out_data,       DW'(8'h99));
    drive(1'b0, 8'h00, 1'b1, 1'b0); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
